// File: rtl/spi_pwm_slave.sv
// SPI slave receiving CHANNELS x WIDTH-bit duty frames (last channel first, MSB first)
// and driving one glitch-free PWM output per channel; everything runs on i_clk.
module spi_pwm_slave #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_cs,
    input  logic                         i_sck,
    input  logic                         i_mosi,
    output logic [CHANNELS*WIDTH-1:0]    o_duty,
    output logic                         o_valid,
    output logic                         o_frame_err,
    output logic [CHANNELS-1:0]          o_pwm
);

    localparam int unsigned NBITS = CHANNELS * WIDTH;
    localparam int unsigned CW    = $clog2(NBITS + 2);
    localparam logic [CW-1:0]    CNT_FULL = CW'(NBITS);
    localparam logic [CW-1:0]    CNT_SAT  = CW'(NBITS + 1);
    localparam logic [WIDTH-1:0] PWM_LAST = WIDTH'((1 << WIDTH) - 2);

    logic cs_meta_q, cs_sync_q, cs_prev_q;
    logic sck_meta_q, sck_sync_q, sck_prev_q;
    logic mosi_meta_q, mosi_sync_q;

    logic [NBITS-1:0] shift_q, shift_d;
    logic [NBITS-1:0] duty_q, duty_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] pwm_cnt_q;
    logic [WIDTH-1:0] active_q [CHANNELS];
    logic [CHANNELS-1:0] pwm_q;

    logic sck_rise, cs_rise, cs_fall;

    // CS stages idle high so leaving reset never looks like a frame end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_prev_q   <= 1'b1;
            sck_meta_q  <= 1'b0;
            sck_sync_q  <= 1'b0;
            sck_prev_q  <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            cs_meta_q   <= i_cs;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
            sck_meta_q  <= i_sck;
            sck_sync_q  <= sck_meta_q;
            sck_prev_q  <= sck_sync_q;
            mosi_meta_q <= i_mosi;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    assign sck_rise = sck_sync_q & ~sck_prev_q;
    assign cs_rise  = cs_sync_q & ~cs_prev_q;
    assign cs_fall  = ~cs_sync_q & cs_prev_q;

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        duty_d    = duty_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        if (cs_fall) begin
            bit_cnt_d = '0;
        end else if (sck_rise && !cs_sync_q) begin
            shift_d = {shift_q[NBITS-2:0], mosi_sync_q};
            if (bit_cnt_q != CNT_SAT) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
        // A zero count is a CS glitch or empty transaction and is ignored
        if (cs_rise) begin
            if (bit_cnt_q == CNT_FULL) begin
                duty_d  = shift_q;
                valid_d = 1'b1;
            end else if (bit_cnt_q != '0) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            duty_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            duty_q    <= duty_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    // Active duties reload only on the wrap so no period is cut or stretched
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pwm_cnt_q <= '0;
            pwm_q     <= '0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                active_q[c] <= '0;
            end
        end else begin
            if (pwm_cnt_q == PWM_LAST) begin
                pwm_cnt_q <= '0;
                for (int unsigned c = 0; c < CHANNELS; c++) begin
                    active_q[c] <= duty_q[c*WIDTH +: WIDTH];
                end
            end else begin
                pwm_cnt_q <= pwm_cnt_q + 1'b1;
            end
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                pwm_q[c] <= (pwm_cnt_q < active_q[c]);
            end
        end
    end

    assign o_duty      = duty_q;
    assign o_valid     = valid_q;
    assign o_frame_err = err_q;
    assign o_pwm       = pwm_q;

endmodule

// File: tb/tb_spi_pwm_slave.sv
// Directed bench for spi_pwm_slave (3 channels x 8 bits): frame table plus
// hand-written PWM shape, mid-period duty change and mid-frame reset sequences.
module tb_spi_pwm_slave;

    localparam int CH   = 3;
    localparam int W    = 8;
    localparam int HALF = 4;

    logic            i_clk;
    logic            i_rst;
    logic            i_cs;
    logic            i_sck;
    logic            i_mosi;
    logic [CH*W-1:0] o_duty;
    logic            o_valid;
    logic            o_frame_err;
    logic [CH-1:0]   o_pwm;

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;
    int n_err   = 0;
    int n_both  = 0;

    spi_pwm_slave #(.CHANNELS(CH), .WIDTH(W)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_cs        (i_cs),
        .i_sck       (i_sck),
        .i_mosi      (i_mosi),
        .o_duty      (o_duty),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
        .o_pwm       (o_pwm)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(negedge i_clk) begin
        if (o_valid) n_valid++;
        if (o_frame_err) n_err++;
        if (o_valid && o_frame_err) n_both++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    typedef struct {
        int          nbits;
        logic [63:0] data;
        logic        exp_v;
        logic        exp_e;
        logic [23:0] exp_duty;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Entered just after a posedge; leaves SCK low just after a posedge
    task automatic send_bits(input logic [63:0] d, input int n);
        for (int b = n - 1; b >= 0; b--) begin
            i_mosi = d[b];
            i_sck  = 1'b0;
            repeat (HALF) @(posedge i_clk);
            #1;
            i_sck = 1'b1;
            repeat (HALF) @(posedge i_clk);
            #1;
        end
        i_sck = 1'b0;
        repeat (HALF) @(posedge i_clk);
        #1;
    endtask

    task automatic start_frame();
        @(posedge i_clk);
        #1;
        i_cs = 1'b0;
        repeat (HALF) @(posedge i_clk);
        #1;
    endtask

    // Raise CS and expect the pulse in the cycle after the 3rd edge only
    task automatic end_frame(input logic exp_v, input logic exp_e);
        i_cs = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            check($sformatf("valid_edge%0d", k), o_valid, (k == 3) && exp_v);
            check($sformatf("ferr_edge%0d", k), o_frame_err, (k == 3) && exp_e);
        end
    endtask

    task automatic wait_rise(output bit found);
        logic prev;
        found = 1'b0;
        @(negedge i_clk);
        prev = o_pwm[1];
        for (int i = 0; i < 800; i++) begin
            @(negedge i_clk);
            if (!prev && o_pwm[1]) begin
                found = 1'b1;
                break;
            end
            prev = o_pwm[1];
        end
    endtask

    initial begin
        bit found;
        int c0, c1, c1_first, c2;
        int h1, h2, vcyc;

        vecs[0] = '{24, 64'h123456,           1'b1, 1'b0, 24'h123456};
        vecs[1] = '{23, 64'h7FFFFF,           1'b0, 1'b1, 24'h123456};
        vecs[2] = '{25, 64'h1ABCDEF,          1'b0, 1'b1, 24'h123456};
        vecs[3] = '{0,  64'h0,                1'b0, 1'b0, 24'h123456};
        vecs[4] = '{56, 64'hFFFFFFFF_AA55AA,  1'b0, 1'b1, 24'h123456};
        vecs[5] = '{24, 64'hA5C30F,           1'b1, 1'b0, 24'hA5C30F};
        vecs[6] = '{24, 64'hFF8000,           1'b1, 1'b0, 24'hFF8000};

        i_rst  = 1'b1;
        i_cs   = 1'b1;
        i_sck  = 1'b0;
        i_mosi = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("reset_duty", o_duty, 0);
        check("reset_valid", o_valid, 0);
        check("reset_ferr", o_frame_err, 0);
        check("reset_pwm", o_pwm, 0);
        repeat (20) @(negedge i_clk);
        check("idle_valid_count", n_valid, 0);
        check("idle_ferr_count", n_err, 0);

        for (int i = 0; i < 7; i++) begin
            start_frame();
            send_bits(vecs[i].data, vecs[i].nbits);
            end_frame(vecs[i].exp_v, vecs[i].exp_e);
            check($sformatf("vec%0d_duty", i), o_duty, vecs[i].exp_duty);
            repeat (4) @(negedge i_clk);
        end

        // Duty 0xFF8000 is latched; let it reach the active registers first
        repeat (260) @(negedge i_clk);
        wait_rise(found);
        check("shape_rise_found", found, 1);
        c0 = 0; c1 = 0; c1_first = 0; c2 = 0;
        for (int s = 0; s < 255; s++) begin
            if (s > 0) @(negedge i_clk);
            c0 += int'(o_pwm[0]);
            c1 += int'(o_pwm[1]);
            c2 += int'(o_pwm[2]);
            if (s < 128) c1_first += int'(o_pwm[1]);
        end
        check("shape_ch2_high", c2, 255);
        check("shape_ch1_high", c1, 128);
        check("shape_ch1_from_start", c1_first, 128);
        check("shape_ch0_high", c0, 0);

        // New channel-1 duty lands about 50 cycles into the period after the rise
        wait_rise(found);
        check("mid_rise_found", found, 1);
        h1 = 0; h2 = 0; vcyc = -1;
        fork
            begin
                repeat (102) @(posedge i_clk);
                #1;
                i_cs = 1'b0;
                repeat (HALF) @(posedge i_clk);
                #1;
                send_bits(64'hFF1000, 24);
                end_frame(1'b1, 1'b0);
            end
            begin
                for (int s = 1; s < 765; s++) begin
                    @(negedge i_clk);
                    if (o_valid) vcyc = s;
                    if (s >= 255 && s < 510) h1 += int'(o_pwm[1]);
                    else if (s >= 510) h2 += int'(o_pwm[1]);
                end
            end
        join
        check("mid_valid_in_period", (vcyc >= 255) && (vcyc < 510), 1);
        check("mid_period_old_duty", h1, 128);
        check("mid_next_period_new_duty", h2, 16);
        check("mid_duty", o_duty, 24'hFF1000);

        start_frame();
        send_bits(64'hABC, 12);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        send_bits(64'hDEF, 12);
        end_frame(1'b0, 1'b1);
        check("rstmid_duty", o_duty, 0);
        repeat (5) @(negedge i_clk);
        check("rstmid_pwm", o_pwm, 0);

        check("total_valid_pulses", n_valid, 4);
        check("total_ferr_pulses", n_err, 4);
        check("valid_ferr_overlap", n_both, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_pwm_slave.md
# spi_pwm_slave

Parametrised SPI slave that receives a frame of CHANNELS duty values, WIDTH bits each, and drives CHANNELS glitch-free PWM outputs. It is the successor to the fixed 3×8-bit RGB receiver. It adds the following:
- all SPI inputs sampled in the system clock domain;
- exact-length frame checking with an error pulse;
- per-channel PWM generation with period-boundary duty update.

It sits between the ESP32 SPI master and the LED/actuator pins.

## Interface
- CHANNELS, 3: number of duty channels / PWM outputs (1..16).
- WIDTH, 8: bits per duty value and PWM resolution (2..12).
- i_clk  in  1  system clock (48 MHz); the only clock in the block.
- i_rst  in  1  reset; synchronous, active-high.
- i_cs  in  1  SPI chip select, active low, asynchronous to i_clk.
- i_sck  in  1  SPI clock, mode 0, asynchronous to i_clk.
- i_mosi  in  1  SPI data, MSB first, asynchronous to i_clk.
- o_duty  out  CHANNELS*WIDTH  latched duty values; channel 0 at [WIDTH-1:0].
- o_valid  out  1  one-cycle pulse when a good frame is latched into o_duty.
- o_frame_err  out  1  one-cycle pulse when a frame of wrong length ends.
- o_pwm  out  CHANNELS  PWM outputs, bit c for channel c.

## Operation
- **Synchronisers.** i_cs, i_sck and i_mosi each pass through a 2-FF synchroniser, followed by a 1-FF delay for edge detection.
  - sck_rise = sync_sck & !prev_sck.
  - cs_rise = sync_cs & !prev_cs.
  - No logic is clocked by i_sck or i_cs.
- **Shift.** On sck_rise while sync_cs=0, shift_reg (CHANNELS*WIDTH bits) shifts left, inserting sync_mosi.
  - bit_cnt increments and saturates at CHANNELS*WIDTH+1.
  - sck_rise while sync_cs=1 is ignored.
- **Frame layout.** The first WIDTH bits are the last channel (CHANNELS-1); the final WIDTH bits are channel 0. This makes o_duty equal to shift_reg directly.
- **Frame start.** A falling edge of sync_cs clears bit_cnt to 0.
- **Frame end (cs_rise):**
  - bit_cnt == CHANNELS*WIDTH: o_duty <= shift_reg and o_valid pulses.
  - bit_cnt == 0: nothing happens; this is a CS glitch or an empty transaction.
  - Any other count: o_frame_err pulses and o_duty is unchanged.
- **PWM counter.** pwm_cnt (WIDTH bits) counts 0..2^WIDTH-2 and wraps to 0, giving a period of 2^WIDTH-1 cycles.
- **Duty loading.** Each channel has an active duty register. All active duty registers load from o_duty only in the cycle where pwm_cnt wraps to 0. A duty change therefore never truncates or extends a period mid-way.
- **PWM output.** o_pwm[c] is registered: o_pwm[c] <= (pwm_cnt < active_duty[c]).
  - duty 0: output constantly low.
  - duty 2^WIDTH-1: output constantly high.
  - duty d: exactly d high cycles per period, high from the start of the period.
- **Reset (i_rst=1 at a clock edge):** everything below clears to 0 on the next edge.
  - Outputs: o_duty, o_valid, o_frame_err, o_pwm.
  - State: shift_reg, bit_cnt, pwm_cnt, active duties.
  - Synchronisers: the cs stages reset to 1 (idle), so that leaving reset does not produce a false cs_rise.
- **Reset mid-frame.** The partial frame is discarded. If CS is still low when reset releases, the remaining bits are counted from 0, so that frame ends in o_frame_err.

## Timing
- Maximum SCK frequency is i_clk/8: each SCK high and low phase must be at least 4 i_clk periods. MOSI must be stable for 3 i_clk cycles around the SCK rising edge.
- After the last SCK rise, CS must stay low for at least 4 i_clk cycles.
- Latency from the CS pin rising to o_valid/o_frame_err high is 3 i_clk edges. The pulse is high during the cycle after the 3rd edge, for exactly one cycle.
- o_duty updates on the same edge that raises o_valid.
- Latency from an o_duty update to a PWM change: up to 2^WIDTH-1 cycles (wait for the wrap) plus 1 cycle (output register).
- o_valid and o_frame_err are never high in the same cycle.
- A back-to-back frame that starts during the o_valid cycle is accepted normally.

## Test plan
- **Reset.** Assert i_rst for 2 cycles → all outputs 0, and no o_valid or o_frame_err for 20 cycles after release with CS high.
- **Good frame.** CHANNELS=3, WIDTH=8; send 0xFF,0x80,0x00 at SCK=i_clk/8 → exactly one o_valid pulse, 3 cycles after CS rises; o_duty=0xFF8000.
- **PWM shape, following the good frame.** Over one full 255-cycle period:
  - o_pwm[2] high for all 255 cycles;
  - o_pwm[1] high for exactly 128 cycles, starting at the period start;
  - o_pwm[0] never high.
- **Wrong length.** Send 23 bits, then 25 bits → o_frame_err pulses each time, no o_valid, o_duty unchanged. CS low→high with no SCK → neither pulse.
- **Duty change mid-period.** Change channel 1 from 0x80 to 0x10 while pwm_cnt=50 → the current period still gives 128 high cycles; the next period gives 16.
- **Reset mid-frame.** Pulse i_rst after 12 bits with CS held low, then clock 12 more bits and raise CS → o_frame_err, o_duty=0, o_pwm all 0.
